// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, registered borrow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             br_next;

    // One full-subtractor cell acting on the current LSBs and the stored borrow
    always_comb begin
        d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    // Next-state logic: load in IDLE, shift one bit per RUN cycle, publish result on last bit
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    sd_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d = {1'b0, sa_q[WIDTH-1:1]};
                sb_d = {1'b0, sb_q[WIDTH-1:1]};
                sd_d = {d_bit, sd_q[WIDTH-1:1]};
                br_d = br_next;
                if (cnt_q == LAST_BIT) begin
                    // Hold cnt on the last bit so it never wraps
                    diff_d  = {d_bit, sd_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle; pulse_at>=0 raises start for the edge E(pulse_at+1)
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, input int pulse_at,
                          output logic [7:0] rd, output logic rb, output int busy_n, output int done_n,
                          output int done_at, output bit held);
        logic [7:0] prev;
        prev    = diff;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        held    = 1'b1;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        for (int k = 0; k < 12; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k < 8 && diff !== prev) held = 1'b0;
            start = (k == pulse_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rd = diff;
        rb = bout;
    endtask

    initial begin
        logic [7:0] rd;
        logic       rb;
        int         busy_n, done_n, done_at, seen;
        bit         held;
        logic [8:0] exp;
        logic [7:0] got_d;
        logic       got_b;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        vecs[4] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_done", 32'(done), 32'd0);
        chk("por_diff", 32'(diff), 32'd0);
        chk("por_bout", 32'(bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, -1, rd, rb, busy_n, done_n, done_at, held);
            chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_bout", i), 32'(rb), 32'(vecs[i].eb));
            chk($sformatf("vec%0d_done_cnt", i), 32'(done_n), 32'd1);
            chk($sformatf("vec%0d_done_at", i), 32'(done_at), 32'd8);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd9);
            chk($sformatf("vec%0d_diff_held", i), 32'(held), 32'd1);
        end

        run_op(8'h10, 8'h01, 1'b0, 2, rd, rb, busy_n, done_n, done_at, held);
        chk("busy_start_diff", 32'(rd), 32'h0F);
        chk("busy_start_bout", 32'(rb), 32'd0);
        chk("busy_start_done_cnt", 32'(done_n), 32'd1);
        chk("busy_start_busy_cycles", 32'(busy_n), 32'd9);

        a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        done_n = 0;
        busy_n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_n++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_n++;
            if (busy) busy_n++;
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        chk("abort_stays_idle", 32'(busy_n), 32'd0);
        chk("abort_diff_after", 32'(diff), 32'd0);
        run_op(8'h03, 8'h05, 1'b0, -1, rd, rb, busy_n, done_n, done_at, held);
        chk("after_abort_diff", 32'(rd), 32'hFE);
        chk("after_abort_bout", 32'(rb), 32'd1);

        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            exp = model(a, b, bin);
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            seen = -1; done_n = 0; got_d = '0; got_b = 1'b0;
            for (int k = 0; k <= 8; k++) begin
                if (done) begin
                    done_n++;
                    if (seen < 0) begin
                        seen  = k;
                        got_d = diff;
                        got_b = bout;
                    end
                end
                if (k < 8) begin
                    @(posedge clk); #1;
                end
            end
            chk($sformatf("rand%0d_result", n), 32'({got_b, got_d}), 32'(exp));
            chk($sformatf("rand%0d_latency", n), 32'(seen), 32'd8);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (12) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
